oc_csr_host_arbiter: RTL

OC_CSR_HOST_ARBITER -- requirements
Module: oc_csr_host_arbiter

---
 rtl/oc_csr_host_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/oc_csr_host_arbiter.sv
// Round-robin arbiter sharing one CSR bus among Hosts requesters; 3 cycles request-to-ack minimum, hosts
// hold hostReq until hostAck, downstream stalls via late downAck; OC_CSR_HOST_ARBITER_TIMEOUT_EN adds an abort timer.
module oc_csr_host_arbiter #(
  parameter int Hosts         = 2,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [Hosts-1:0]              hostReq,
  input  logic [Hosts-1:0]              hostWrite,
  input  logic [Hosts*AddressWidth-1:0] hostAddress,
  input  logic [Hosts*DataWidth-1:0]    hostWdata,
  output logic [Hosts-1:0]              hostAck,
  output logic [DataWidth-1:0]          hostRdata,
  output logic                          hostError,
  output logic                          downReq,
  output logic                          downWrite,
  output logic [AddressWidth-1:0]       downAddress,
  output logic [DataWidth-1:0]          downWdata,
  input  logic                          downAck,
  input  logic                          downError,
  input  logic [DataWidth-1:0]          downRdata,
  output logic [2:0]                    grantId,
  output logic                          busy,
  output logic                          timeoutEvent
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                  state, stateNext;
  logic [2:0]              lastGrant;
  logic [2:0]              winner;
  logic                    anyReq;
  logic [3:0]              rrTarget;
  logic                    selWrite;
  logic [AddressWidth-1:0] selAddress;
  logic [DataWidth-1:0]    selWdata;
  logic [DataWidth-1:0]    rdataReg;
  logic                    errorReg;
  logic                    limitHit;

  if (Hosts < 1 || Hosts > 8) begin : gBadHosts
    $error("oc_csr_host_arbiter: Hosts must be 1..8");
  end
  if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : gBadTimeout
    $error("oc_csr_host_arbiter: TimeoutCycles must be 2..65535");
  end

  // Walk offsets from farthest to nearest so the host right after lastGrant wins.
  always_comb begin
    winner     = '0;
    anyReq     = 1'b0;
    rrTarget   = '0;
    selWrite   = 1'b0;
    selAddress = '0;
    selWdata   = '0;
    for (int i = Hosts; i >= 1; i--) begin
      rrTarget = {1'b0, lastGrant} + 4'(i);
      if (rrTarget >= 4'(Hosts)) rrTarget = rrTarget - 4'(Hosts);
      for (int h = 0; h < Hosts; h++) begin
        if (rrTarget == 4'(h) && hostReq[h]) begin
          winner = 3'(h);
          anyReq = 1'b1;
        end
      end
    end
    for (int h = 0; h < Hosts; h++) begin
      if (winner == 3'(h)) begin
        selWrite   = hostWrite[h];
        selAddress = hostAddress[h*AddressWidth +: AddressWidth];
        selWdata   = hostWdata[h*DataWidth +: DataWidth];
      end
    end
  end

`ifdef OC_CSR_HOST_ARBITER_TIMEOUT_EN
  logic [15:0] waitCount;

  always_ff @(posedge clock) begin
    if (reset) begin
      waitCount <= '0;
    end else if (state == IDLE) begin
      waitCount <= '0;
    end else if (state == REQ && !downAck) begin
      waitCount <= waitCount + 16'd1;
    end
  end

  assign limitHit = (waitCount == 16'(TimeoutCycles - 1));
`else
  assign limitHit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    downReq      = 1'b0;
    hostAck      = '0;
    timeoutEvent = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) stateNext = REQ;
      end
      REQ: begin
        downReq = 1'b1;
        if (downAck) begin
          stateNext = RESP;
        end else if (limitHit) begin
          stateNext    = RESP;
          timeoutEvent = 1'b1;
        end
      end
      RESP: begin
        hostAck   = Hosts'(1) << grantId;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lastGrant   <= 3'(Hosts - 1);
      grantId     <= '0;
      downWrite   <= 1'b0;
      downAddress <= '0;
      downWdata   <= '0;
      rdataReg    <= '0;
      errorReg    <= 1'b0;
    end else begin
      if (state == IDLE && anyReq) begin
        lastGrant   <= winner;
        grantId     <= winner;
        downWrite   <= selWrite;
        downAddress <= selAddress;
        downWdata   <= selWdata;
      end
      if (state == REQ) begin
        if (downAck) begin
          errorReg <= downError;
          rdataReg <= (downError || downWrite) ? '0 : downRdata;
        end else if (limitHit) begin
          errorReg <= 1'b1;
          rdataReg <= '0;
        end
      end
    end
  end

  // Response fields are only meaningful alongside hostAck, so keep them quiet otherwise.
  assign hostRdata = (state == RESP) ? rdataReg : '0;
  assign hostError = (state == RESP) ? errorReg : 1'b0;
  assign busy      = (state != IDLE);

endmodule
